// File: rtl/aux_dispatch_pkg.sv
// Shared constants and launch-state encoding for the auxiliary accelerator launcher.
package aux_dispatch_pkg;

  localparam int unsigned RV_BIT_NUM  = 32;
  localparam int unsigned AUX_CNT_W   = 16;
  localparam int unsigned AUX_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    AUX_DSP_IDLE   = 2'd0,
    AUX_DSP_LAUNCH = 2'd1,
    AUX_DSP_DRAIN  = 2'd2,
    AUX_DSP_RESP   = 2'd3
  } aux_dsp_state_e;

  // Bits needed to count 0..timeout-1; at least one bit even when disabled.
  function automatic int unsigned aux_to_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/aux_dispatch_timer.sv
// Saturating busy-cycle counter plus a per-phase timeout counter and comparator.
module aux_dispatch_timer
  import aux_dispatch_pkg::*;
#(
  parameter int unsigned CNT_W   = AUX_CNT_W,
  parameter int unsigned TIMEOUT = AUX_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             clr_to_i,
  input  logic             en_cnt_i,
  input  logic             en_to_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expired_c_o
);

  localparam int unsigned     TO_W      = aux_to_width(TIMEOUT);
  localparam int unsigned     TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_q, to_d;

  // Cycle count sticks at all-ones rather than wrapping.
  always_comb begin
    count_d = count_q;
    to_d    = to_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_cnt_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
    if (clr_i || clr_to_i) begin
      to_d = '0;
    end else if (en_to_i) begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      to_q    <= '0;
    end else begin
      count_q <= count_d;
      to_q    <= to_d;
    end
  end

  assign count_o     = count_q;
  assign expired_c_o = (TIMEOUT != 0) && (to_q == TO_LAST);

endmodule

// File: rtl/aux_dispatch.sv
// Launches the auxiliary accelerator, waits for its done level to rise and fall,
// and returns cycle count plus timeout status to the core.
module aux_dispatch
  import aux_dispatch_pkg::*;
#(
  parameter int unsigned XLEN    = RV_BIT_NUM,
  parameter int unsigned CNT_W   = AUX_CNT_W,
  parameter int unsigned TIMEOUT = AUX_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [XLEN-1:0]  cmd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             busy,
  output logic             aux_en,
  output logic [XLEN-1:0]  aux_start_addr,
  input  logic             aux_done
);

  aux_dsp_state_e   state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic             rsp_to_q, rsp_to_d;
  logic             aux_en_q, aux_en_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             tmr_clr, tmr_clr_to, tmr_en_cnt, tmr_en_to, tmr_expired;
  logic [CNT_W-1:0] tmr_count;

  assign tmr_en_cnt = (state_q == AUX_DSP_LAUNCH);
  assign tmr_en_to  = (state_q == AUX_DSP_LAUNCH) || (state_q == AUX_DSP_DRAIN);

  aux_dispatch_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .clr_to_i   (tmr_clr_to),
    .en_cnt_i   (tmr_en_cnt),
    .en_to_i    (tmr_en_to),
    .count_o    (tmr_count),
    .expired_c_o(tmr_expired)
  );

  // Next state; in LAUNCH a sampled done beats a coincident timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rsp_to_d   = rsp_to_q;
    tmr_clr    = 1'b0;
    tmr_clr_to = 1'b0;
    case (state_q)
      AUX_DSP_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = AUX_DSP_LAUNCH;
          addr_d   = cmd_addr;
          rsp_to_d = 1'b0;
          tmr_clr  = 1'b1;
        end
      end
      AUX_DSP_LAUNCH: begin
        if (aux_done) begin
          state_d    = AUX_DSP_DRAIN;
          tmr_clr_to = 1'b1;
        end else if (tmr_expired) begin
          state_d    = AUX_DSP_DRAIN;
          rsp_to_d   = 1'b1;
          tmr_clr_to = 1'b1;
        end
      end
      AUX_DSP_DRAIN: begin
        if (!aux_done) begin
          state_d = AUX_DSP_RESP;
        end else if (tmr_expired) begin
          state_d  = AUX_DSP_RESP;
          rsp_to_d = 1'b1;
        end
      end
      AUX_DSP_RESP: begin
        if (rsp_ready) begin
          state_d = AUX_DSP_IDLE;
        end
      end
      default: state_d = AUX_DSP_IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_comb begin
    aux_en_d    = (state_d == AUX_DSP_LAUNCH);
    busy_d      = (state_d != AUX_DSP_IDLE);
    rsp_valid_d = (state_d == AUX_DSP_RESP);
    cmd_ready_d = (state_d == AUX_DSP_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= AUX_DSP_IDLE;
      addr_q      <= '0;
      rsp_to_q    <= 1'b0;
      aux_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_to_q    <= rsp_to_d;
      aux_en_q    <= aux_en_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_timeout    = rsp_to_q;
  assign rsp_cycles     = tmr_count;
  assign busy           = busy_q;
  assign aux_en         = aux_en_q;
  assign aux_start_addr = addr_q;

endmodule

// File: tb/tb_aux_dispatch.sv
// Bench for aux_dispatch: directed and randomized launches against a behavioural
// accelerator and an arithmetic model of the expected response timing.
module tb_aux_dispatch;
  import aux_dispatch_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int TO    = 8;
  localparam int SAT_W = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic             cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic             busy, aux_en, aux_done;
  logic [XLEN-1:0]  cmd_addr, aux_start_addr;
  logic [CNT_W-1:0] rsp_cycles;

  logic             s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_rsp_timeout;
  logic             s_busy, s_aux_en, s_aux_done;
  logic [XLEN-1:0]  s_cmd_addr, s_aux_start_addr;
  logic [SAT_W-1:0] s_rsp_cycles;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Accelerator behaviour knobs and its internal run counters
  int   acc_lat, acc_hold, en_run, lo_run;
  bit   acc_never, acc_stuck;
  logic en_prev;

  always #5 clk = ~clk;

  aux_dispatch #(.XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles), .busy(busy),
    .aux_en(aux_en), .aux_start_addr(aux_start_addr), .aux_done(aux_done)
  );

  aux_dispatch #(.XLEN(XLEN), .CNT_W(SAT_W), .TIMEOUT(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_addr(s_cmd_addr), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_timeout(s_rsp_timeout), .rsp_cycles(s_rsp_cycles), .busy(s_busy),
    .aux_en(s_aux_en), .aux_start_addr(s_aux_start_addr), .aux_done(s_aux_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; done rises after acc_lat en-high cycles and falls acc_hold+1 cycles after en drops.
  task automatic tick();
    en_prev = aux_en;
    @(posedge clk);
    #1;
    if (en_prev === 1'b1) begin
      en_run++;
      lo_run = 0;
      if (!acc_never && en_run >= acc_lat) aux_done = 1'b1;
    end else begin
      en_run = 0;
      if (aux_done === 1'b1) begin
        lo_run++;
        if (!acc_stuck && lo_run > acc_hold) aux_done = 1'b0;
      end
    end
  endtask

  task automatic run_launch(input logic [XLEN-1:0] addr, input int lat, input bit never,
                            input bit stuck, input int hold, input int rdy_wait, input bit b2b);
    int L, D, j0, cyc, en_bad, addr_bad, busy_bad, stab_bad;
    bit exp_to, raised;
    // Expected LAUNCH length L and DRAIN length D from the accelerator schedule
    if (!never && (TO == 0 || lat + 1 <= TO)) begin
      L = lat + 1; exp_to = 1'b0;
    end else begin
      L = TO;      exp_to = 1'b1;
    end
    raised = !never && (lat <= L);
    j0 = !raised ? 1 : (stuck ? 1000 : hold + 2);
    if (TO != 0 && j0 > TO) begin
      D = TO; exp_to = 1'b1;
    end else begin
      D = j0;
    end

    acc_lat = lat; acc_never = never; acc_stuck = stuck; acc_hold = hold;
    en_run = 0; lo_run = 0; aux_done = 1'b0;
    cmd_addr = addr; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom();
    cyc = 1; en_bad = 0; addr_bad = 0; busy_bad = 0; stab_bad = 0;
    while (cyc < 100 && rsp_valid !== 1'b1) begin
      if (aux_en !== (cyc <= L)) en_bad++;
      if (aux_start_addr !== addr) addr_bad++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_bad++;
      tick();
      cyc++;
    end
    chk("rsp_latency", 64'(cyc), 64'(L + D + 1));
    chk("aux_en_window", 64'(en_bad), 64'(0));
    chk("start_addr_held", 64'(addr_bad), 64'(0));
    chk("busy_during_launch", 64'(busy_bad), 64'(0));
    chk("rsp_cycles", 64'(rsp_cycles), 64'(L));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));

    rsp_ready = 1'b0;
    for (int k = 0; k < rdy_wait; k++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_cycles !== CNT_W'(L) || rsp_timeout !== exp_to ||
          cmd_ready !== 1'b0 || aux_en !== 1'b0 || busy !== 1'b1) stab_bad++;
    end
    chk("resp_hold_stable", 64'(stab_bad), 64'(0));

    rsp_ready = 1'b1;
    cmd_valid = b2b;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_dropped", 64'(rsp_valid), 64'(0));
    chk("idle_after_rsp", 64'({busy, aux_en, cmd_ready}), 64'(3'b001));
  endtask

  initial begin
    int cyc, bad;
    logic [XLEN-1:0] a;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; rsp_ready = 1'b0; aux_done = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_addr = '0; s_rsp_ready = 1'b0; s_aux_done = 1'b0;
    acc_lat = 1; acc_hold = 0; acc_never = 1'b0; acc_stuck = 1'b0; en_run = 0; lo_run = 0;

    // Mid-cycle asynchronous reset
    #3 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({aux_en, busy, rsp_valid, rsp_timeout}), 64'(0));
    chk("rst_cycles", 64'(rsp_cycles), 64'(0));
    chk("rst_addr", 64'(aux_start_addr), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
    chk("sat_cmd_ready_after_rst", 64'(s_cmd_ready), 64'(1));

    // Directed: nominal, never-done, coincident done/timeout, done one late, stuck done
    run_launch(32'h0000_1000, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    run_launch($urandom(), 1, 1'b1, 1'b0, 0, 0, 1'b0);
    run_launch($urandom(), 7, 1'b0, 1'b0, 0, 1, 1'b0);
    run_launch($urandom(), 8, 1'b0, 1'b0, 1, 0, 1'b0);
    run_launch($urandom(), 1, 1'b0, 1'b1, 0, 2, 1'b0);
    // Long response stall followed by a back-to-back command
    run_launch($urandom(), 3, 1'b0, 1'b0, 2, 10, 1'b1);
    run_launch($urandom(), 2, 1'b0, 1'b0, 0, 0, 1'b0);

    // Reset mid-launch aborts without a response
    a = $urandom();
    acc_lat = 5; acc_never = 1'b0; acc_stuck = 1'b0; acc_hold = 0;
    en_run = 0; lo_run = 0; aux_done = 1'b0;
    cmd_addr = a; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre_abort_en", 64'(aux_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en_drop", 64'(aux_en), 64'(0));
    chk("abort_outputs", 64'({busy, rsp_valid, rsp_timeout}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    aux_done = 1'b0; en_run = 0; lo_run = 0;
    bad = 0;
    repeat (6) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || aux_en !== 1'b0) bad++;
    end
    chk("no_rsp_after_abort", 64'(bad), 64'(0));
    run_launch(32'h0000_1000, 1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Randomized launches
    for (int n = 0; n < 14; n++) begin
      bit b2b;
      b2b = ($urandom_range(0, 1) == 1);
      run_launch($urandom(), int'($urandom_range(1, 10)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), b2b);
      if (!b2b) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
          aux_done = ($urandom_range(0, 1) == 1);
          tick();
        end
      end
    end
    cmd_valid = 1'b0;

    // Saturating counter with the timeout disabled: 21 launch cycles into a 3-bit count
    a = $urandom();
    s_cmd_addr = a; s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 60 && s_rsp_valid !== 1'b1) begin
      s_aux_done = (cyc == 21);
      tick();
      cyc++;
    end
    chk("sat_latency", 64'(cyc), 64'(23));
    chk("sat_rsp_cycles", 64'(s_rsp_cycles), 64'(7));
    chk("sat_rsp_timeout", 64'(s_rsp_timeout), 64'(0));
    chk("sat_start_addr", 64'(s_aux_start_addr), 64'(a));
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    chk("sat_idle", 64'({s_busy, s_rsp_valid, s_cmd_ready}), 64'(3'b001));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
